// File: rtl/soc_system_event_counter.sv
// Synchronised, glitch-filtered edge counter with a software-visible snapshot for a PIO in_port.
// Define EVENT_COUNTER_SATURATE_EN to saturate at all-ones instead of wrapping.
module soc_system_event_counter #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned FILTER_CYCLES = 4,   // 1..255, 1 = no filtering
  parameter int unsigned EDGE          = 0    // 0 rising, 1 falling, 2 both
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             event_in,
  input  logic             enable,
  input  logic             clear,
  input  logic             latch,
  output logic [WIDTH-1:0] count_live,
  output logic [WIDTH-1:0] count_out,
  output logic             overflow,
  output logic             event_pulse
);

  localparam logic [7:0] FILTER_LIMIT = 8'(FILTER_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic [7:0]       r_filt_cnt;
  logic [WIDTH-1:0] r_count_live;
  logic [WIDTH-1:0] r_count_out;
  logic             r_overflow;
  logic             r_event_pulse;

  logic [7:0]       w_filt_next;
  logic             w_edge;
  logic             w_count_inc;
  logic             w_count_full;
  logic [WIDTH-1:0] w_count_next;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= event_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_filt_next = r_filt_cnt + 8'd1;

  // A new level is accepted only after it has differed from r_stable for FILTER_CYCLES edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_filt_cnt <= 8'd0;
    end else begin
      r_stable_d <= r_stable;
      if (r_sync2 == r_stable) begin
        r_filt_cnt <= 8'd0;
      end else if (w_filt_next == FILTER_LIMIT) begin
        r_stable   <= r_sync2;
        r_filt_cnt <= 8'd0;
      end else begin
        r_filt_cnt <= w_filt_next;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_edge = 1'b0;
    case (EDGE)
      0:       w_edge = r_stable & ~r_stable_d;
      1:       w_edge = ~r_stable & r_stable_d;
      default: w_edge = r_stable ^ r_stable_d;
    endcase
  end

  assign w_count_inc  = w_edge & enable;
  assign w_count_full = &r_count_live;

`ifdef EVENT_COUNTER_SATURATE_EN
  assign w_count_next = w_count_full ? r_count_live : r_count_live + WIDTH'(1);
`else
  assign w_count_next = r_count_live + WIDTH'(1);
`endif

  // clear beats increment; the snapshot always takes the pre-update live value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count_live  <= '0;
      r_count_out   <= '0;
      r_overflow    <= 1'b0;
      r_event_pulse <= 1'b0;
    end else begin
      r_event_pulse <= w_count_inc;
      if (latch) begin
        r_count_out <= r_count_live;
      end
      if (clear) begin
        r_count_live <= '0;
        r_overflow   <= 1'b0;
      end else if (w_count_inc) begin
        r_count_live <= w_count_next;
        if (w_count_full) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  assign count_live  = r_count_live;
  assign count_out   = r_count_out;
  assign overflow    = r_overflow;
  assign event_pulse = r_event_pulse;

endmodule

// File: tb/tb_soc_system_event_counter.sv
// Three counter instances share one stimulus stream; each is compared every cycle with a
// window-based reference model, plus directed checks for the key scenarios.
module tb_soc_system_event_counter;

  logic clk;
  logic reset_n;
  logic event_in;
  logic enable;
  logic clear;
  logic latch;

  logic [31:0] rise_live, rise_out, both_live, both_out;
  logic        rise_ovf, rise_pulse, both_ovf, both_pulse;
  logic [3:0]  sm_live, sm_out;
  logic        sm_ovf, sm_pulse;

  int n_checks = 0;
  int n_errors = 0;

  // rising, 32 bit, filter 4
  soc_system_event_counter #(.WIDTH(32), .FILTER_CYCLES(4), .EDGE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .event_in(event_in), .enable(enable),
    .clear(clear), .latch(latch), .count_live(rise_live), .count_out(rise_out),
    .overflow(rise_ovf), .event_pulse(rise_pulse));

  // both edges, 32 bit, filter 4
  soc_system_event_counter #(.WIDTH(32), .FILTER_CYCLES(4), .EDGE(2)) u_both (
    .clk(clk), .reset_n(reset_n), .event_in(event_in), .enable(enable),
    .clear(clear), .latch(latch), .count_live(both_live), .count_out(both_out),
    .overflow(both_ovf), .event_pulse(both_pulse));

  // falling, 4 bit, no filtering: reaches overflow quickly
  soc_system_event_counter #(.WIDTH(4), .FILTER_CYCLES(1), .EDGE(1)) u_small (
    .clk(clk), .reset_n(reset_n), .event_in(event_in), .enable(enable),
    .clear(clear), .latch(latch), .count_live(sm_live), .count_out(sm_out),
    .overflow(sm_ovf), .event_pulse(sm_pulse));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] o_live [3];
  logic [31:0] o_out  [3];
  logic        o_ovf  [3];
  logic        o_pulse[3];
  assign o_live[0] = rise_live;           assign o_out[0] = rise_out;
  assign o_live[1] = both_live;           assign o_out[1] = both_out;
  assign o_live[2] = {28'd0, sm_live};    assign o_out[2] = {28'd0, sm_out};
  assign o_ovf[0] = rise_ovf;  assign o_pulse[0] = rise_pulse;
  assign o_ovf[1] = both_ovf;  assign o_pulse[1] = both_pulse;
  assign o_ovf[2] = sm_ovf;    assign o_pulse[2] = sm_pulse;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned m_filter[3];
  int unsigned m_edge  [3];
  int unsigned m_width [3];
  bit          m_stable  [3];
  bit          m_stable_d[3];
  bit          m_pulse   [3];
  bit          m_ovf     [3];
  logic [31:0] m_cnt     [3];
  logic [31:0] m_out     [3];
  bit          raw_q[$];   // event_in as sampled on each edge since reset

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_stable[i] = 0; m_stable_d[i] = 0; m_pulse[i] = 0; m_ovf[i] = 0;
      m_cnt[i] = '0;   m_out[i] = '0;
    end
    raw_q.delete();
    for (int k = 0; k < 8; k++) raw_q.push_back(1'b0);
  endfunction

  // One rising clock edge. The level seen by the filter at edge n is event_in sampled at
  // edge n-2; the accepted level flips once the last FILTER_CYCLES filter inputs all differ.
  function automatic void model_step(input bit ev, input bit en, input bit clr, input bit lat);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] mask;
      bit          seen;
      bit          flip;
      mask = (m_width[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << m_width[i]) - 32'd1);
      case (m_edge[i])
        0:       seen = m_stable[i] && !m_stable_d[i];
        1:       seen = !m_stable[i] && m_stable_d[i];
        default: seen = m_stable[i] != m_stable_d[i];
      endcase
      m_pulse[i] = seen && en;
      if (lat) m_out[i] = m_cnt[i];
      if (clr) begin
        m_cnt[i] = '0;
        m_ovf[i] = 0;
      end else if (seen && en) begin
        if (m_cnt[i] == mask) begin
          m_ovf[i] = 1;
`ifdef EVENT_COUNTER_SATURATE_EN
          m_cnt[i] = mask;
`else
          m_cnt[i] = '0;
`endif
        end else begin
          m_cnt[i] = m_cnt[i] + 32'd1;
        end
      end
      flip = 1;
      for (int k = 2; k <= int'(m_filter[i]) + 1; k++)
        if (raw_q[raw_q.size() - k] == m_stable[i]) flip = 0;
      m_stable_d[i] = m_stable[i];
      if (flip) m_stable[i] = !m_stable[i];
    end
    raw_q.push_back(ev);
    if (raw_q.size() > 16) void'(raw_q.pop_front());
  endfunction

  task automatic compare_all();
    string nm[3];
    nm[0] = "rise"; nm[1] = "both"; nm[2] = "small";
    for (int i = 0; i < 3; i++) begin
      check({nm[i], ".count_live"},  o_live[i],  m_cnt[i]);
      check({nm[i], ".count_out"},   o_out[i],   m_out[i]);
      check({nm[i], ".overflow"},    32'(o_ovf[i]),   32'(m_ovf[i]));
      check({nm[i], ".event_pulse"}, 32'(o_pulse[i]), 32'(m_pulse[i]));
    end
  endtask

  // One clock: model follows the rising edge, DUT is sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step(event_in, enable, clear, latch);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_in(input int hi, input int lo);
    event_in = 1'b1; idle(hi);
    event_in = 1'b0; idle(lo);
  endtask

  task automatic pulse_ctrl(input bit c, input bit l);
    clear = c; latch = l; tick();
    clear = 1'b0; latch = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int k;
    int kk;
    m_filter[0] = 4; m_edge[0] = 0; m_width[0] = 32;
    m_filter[1] = 4; m_edge[1] = 2; m_width[1] = 32;
    m_filter[2] = 1; m_edge[2] = 1; m_width[2] = 4;
    reset_n = 1'b0; event_in = 1'b0; enable = 1'b1; clear = 1'b0; latch = 1'b0;
    model_reset();

    // reset state
    repeat (2) @(negedge clk);
    check("reset.count_live", rise_live, 32'd0);
    check("reset.count_out", rise_out, 32'd0);
    check("reset.overflow", 32'(rise_ovf), 32'd0);
    check("reset.event_pulse", 32'(rise_pulse), 32'd0);
    reset_n = 1'b1;
    idle(3);

    // basic count: pulse appears on the 7th edge after the input rise
    for (int p = 0; p < 10; p++) begin
      event_in = 1'b1;
      lat = -1;
      for (int e = 1; e <= 8; e++) begin
        tick();
        if (lat < 0 && rise_pulse) lat = e;
      end
      check("basic.latency", 32'(lat), 32'd7);
      event_in = 1'b0;
      idle(8);
    end
    check("basic.count_live", rise_live, 32'd10);
    pulse_ctrl(1'b0, 1'b1);
    check("basic.count_out", rise_out, 32'd10);

    // glitch reject: 3-cycle pulse dropped, 4-cycle pulse accepted
    pulse_ctrl(1'b1, 1'b0);
    pulse_in(3, 8);
    check("glitch.filter_cnt", 32'(u_rise.r_filt_cnt), 32'd0);
    check("glitch.rejected", rise_live, 32'd0);
    pulse_in(4, 10);
    check("glitch.accepted", rise_live, 32'd1);

    // both edges, then disabled pulses, then re-enable without a spurious count
    pulse_ctrl(1'b1, 1'b0);
    repeat (5) pulse_in(8, 8);
    idle(2);
    check("edge_both.count", both_live, 32'd10);
    check("edge_rise.count", rise_live, 32'd5);
    enable = 1'b0;
    repeat (3) pulse_in(8, 8);
    idle(2);
    enable = 1'b1;
    idle(10);
    check("enable.no_spurious", both_live, 32'd10);
    pulse_in(8, 10);
    check("enable.resumed", both_live, 32'd12);

    // atomic read-and-clear on the edge that also counts an event
    pulse_ctrl(1'b1, 1'b0);
    kk = int'($urandom_range(3, 9));
    repeat (kk) pulse_in(8, 8);
    event_in = 1'b1;
    idle(6);
    clear = 1'b1; latch = 1'b1;
    tick();
    clear = 1'b0; latch = 1'b0;
    check("rdclr.count_out", rise_out, 32'(kk));
    check("rdclr.count_live", rise_live, 32'd0);
    check("rdclr.event_pulse", 32'(rise_pulse), 32'd1);
    event_in = 1'b0;
    idle(8);

    // overflow on the 4-bit falling-edge instance
    pulse_ctrl(1'b1, 1'b0);
    repeat (15) pulse_in(3, 3);
    idle(4);
    check("ovf.pre_count", 32'(sm_live), 32'd15);
    check("ovf.pre_flag", 32'(sm_ovf), 32'd0);
    pulse_in(3, 4);
`ifdef EVENT_COUNTER_SATURATE_EN
    check("ovf.count", 32'(sm_live), 32'd15);
`else
    check("ovf.count", 32'(sm_live), 32'd0);
`endif
    check("ovf.flag", 32'(sm_ovf), 32'd1);
    pulse_ctrl(1'b1, 1'b0);
    check("ovf.cleared", 32'(sm_ovf), 32'd0);

    // reset mid-filter / mid-count
    pulse_ctrl(1'b1, 1'b0);
    repeat (7) pulse_in(8, 8);
    event_in = 1'b1;
    k = 0;
    while (u_rise.r_filt_cnt != 8'd2 && k < 10) begin
      tick();
      k++;
    end
    check("midrst.filter_cnt", 32'(u_rise.r_filt_cnt), 32'd2);
    check("midrst.count_live", rise_live, 32'd7);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("midrst.count_live0", rise_live, 32'd0);
    check("midrst.count_out0", rise_out, 32'd0);
    check("midrst.overflow0", 32'(rise_ovf), 32'd0);
    check("midrst.pulse0", 32'(rise_pulse), 32'd0);
    @(negedge clk);
    idle(2);
    reset_n = 1'b1;
    // E0 is the first edge after release; the count lands on E(FILTER_CYCLES+2)
    idle(6);
    check("midrst.before", rise_live, 32'd0);
    tick();
    check("midrst.counted", rise_live, 32'd1);
    check("midrst.pulse", 32'(rise_pulse), 32'd1);
    idle(10);
    check("midrst.single", rise_live, 32'd1);

    // randomized traffic against the model
    for (int s = 0; s < 400; s++) begin
      event_in = 1'($urandom_range(0, 1));
      enable   = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < int'($urandom_range(1, 10)); c++) begin
        clear = ($urandom_range(0, 39) == 0);
        latch = ($urandom_range(0, 7) == 0);
        tick();
      end
      clear = 1'b0; latch = 1'b0;
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/soc_system_event_counter.md
# soc_system_event_counter

Upstream producer for the 32-bit count PIO input port.
- Synchronises and glitch-filters an asynchronous external event line.
- Detects the configured edge and counts accepted events in a free-running counter.
- Presents a software-visible snapshot on `count_out`, which drives the PIO `in_port` so the HPS reads a stable value over Avalon.

## Interface
Parameters:
- `WIDTH`, 32: counter, live value and snapshot width.
- `FILTER_CYCLES`, 4: consecutive cycles the synchronised input must hold a new level before it is accepted. Legal range is 1..255; 1 means no filtering.
- `EDGE`, 0: event edge to count. 0 = rising, 1 = falling, 2 = both.

Ports:
- `clk`  in  1: system clock; all logic is in this single domain.
- `reset_n`  in  1: asynchronous, active-low reset.
- `event_in`  in  1: raw asynchronous event line.
- `enable`  in  1: synchronous count enable.
- `clear`  in  1: synchronous one-cycle pulse that zeroes `count_live` and `overflow`.
- `latch`  in  1: synchronous one-cycle pulse that copies `count_live` into `count_out`.
- `count_live`  out  WIDTH: running count register.
- `count_out`  out  WIDTH: snapshot register; connects to PIO `in_port`.
- `overflow`  out  1: sticky overflow flag.
- `event_pulse`  out  1: one-cycle registered pulse per counted event.

## Operation
- **Synchroniser:** `event_in` goes through two flops, `sync1` then `sync2`.
- **Filter:** a `stable` level register and a filter counter, `ceil(log2(256))` = 8 bits.
  - Each edge where `sync2 != stable`, the filter counter increments.
  - When it reaches `FILTER_CYCLES`, `stable <= sync2` on that same edge and the filter counter resets to 0.
  - Any edge where `sync2 == stable` resets the filter counter to 0.
  - Result: pulses shorter than `FILTER_CYCLES` cycles at `sync2` are rejected.
- **Edge detect:** compares `stable` with its one-cycle delayed copy `stable_d`, according to `EDGE`.
  - `stable_d` and `stable` always track, regardless of `enable`.
  - Re-enabling therefore never produces a spurious edge.
- **Count:** on a detected edge with `enable=1`, `count_live` increments by 1 and `event_pulse` asserts for exactly one cycle. With `enable=0`, edges are dropped and `event_pulse` stays 0.
- **Priority, same cycle:** `clear` wins over increment.
  - With `clear=1`, `count_live` goes to 0 and `overflow` goes to 0.
  - `event_pulse` still asserts if an event was detected and `enable=1`.
- **Latch:** `count_out` loads the pre-update value of `count_live`, i.e. the register value before any same-edge increment or clear.
  - `latch` together with `clear` is an atomic read-and-clear.
  - `count_out` is changed only by `latch` and by reset.
- **Wrap (default):** increment from all-ones gives 0 and sets `overflow`.
- **Arithmetic:** unsigned modulo 2^WIDTH; no signed interpretation.
- **Reset:** all outputs and internal registers go to 0 (`count_live`, `count_out`, `overflow`, `event_pulse`, `sync1`, `sync2`, `stable`, `stable_d`, filter counter).
  - If `event_in` is high through reset, one rising event is counted `FILTER_CYCLES+2` edges after release, provided `enable=1`.
  - Asserting reset mid-filter or mid-count discards all state immediately. No partial increment survives.

## Timing
- Let E0 be the first `clk` edge that samples a new `event_in` level into `sync1`.
  - `sync2` updates at E1.
  - `stable` updates at E(1+FILTER_CYCLES).
  - `count_live` and `event_pulse` update at E(2+FILTER_CYCLES).
  - Total latency is `FILTER_CYCLES+3` edges; with the default of 4, this is 7 edges including E0.
- `latch` sampled high at edge N makes the value visible on `count_out` after edge N. PIO `readdata` adds its own one cycle.
- `clear` sampled at edge N makes `count_live` 0 after edge N.
- Maximum countable rate is one accepted level change per `FILTER_CYCLES` cycles; faster toggling is filtered out, not miscounted.

## Configuration
- **`EVENT_COUNTER_SATURATE_EN` defined:** the counter saturates.
  - At all-ones, a further enabled event leaves `count_live` at all-ones and sets `overflow`.
  - `event_pulse` still asserts.
- **`EVENT_COUNTER_SATURATE_EN` undefined:** wrap behaviour as described in Operation.

## Test plan
- **Basic count:** reset; `enable=1`, `EDGE=0`, `FILTER_CYCLES=4`; 10 clean high pulses of 8 cycles each, 8 cycles low between.
  - `count_live=10` and 10 `event_pulse`s, each pulse 7 edges after its input rise.
  - Then `latch` gives `count_out=10`.
- **Glitch reject:** 3-cycle high pulse, then 4-cycle high pulse.
  - Exactly 1 count.
  - Filter counter returns to 0 after the glitch.
- **Edge modes and enable:** `EDGE=2`, 5 full pulses gives a count of 10.
  - `enable=0` during 3 further pulses adds 0 counts, with no spurious count on re-enable.
- **Read-and-clear:** `count_live=0x1234`; `latch` and `clear` in the same cycle as a detected event.
  - `count_out=0x1234` and `count_live=0`.
  - `event_pulse` asserts.
- **Overflow:** force `count_live=0xFFFFFFFF` via a back-door write, then one event.
  - Without the macro: `count_live=0`, `overflow=1`.
  - With `EVENT_COUNTER_SATURATE_EN`: `count_live=0xFFFFFFFF`, `overflow=1`.
  - A subsequent `clear` gives `overflow=0`.
- **Reset mid-operation:** assert `reset_n=0` while the filter counter is 2 and `count_live=7`.
  - All outputs read 0 immediately.
  - `event_in` held high gives exactly 1 count `FILTER_CYCLES+2` edges after release.
